// File: rtl/mult_div_unit_pkg.sv
// md_pkg: MD op / HI-LO read encodings and FSM state constants shared with decode.
package md_pkg;
    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;
    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b01;
    localparam logic [1:0] HILO_LO   = 2'b10;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage request/response bundle between the pipeline and the HI/LO unit.
interface mult_div_unit_if;
    logic [2:0]  MDop;
    logic [1:0]  HILO_Rop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        start;
    logic        busy;
    logic [31:0] rdata;
    modport master (output MDop, HILO_Rop, rs_data, rt_data, cancel, input start, busy, rdata);
    modport slave  (input MDop, HILO_Rop, rs_data, rt_data, cancel, output start, busy, rdata);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/div owning HI/LO; result computed at start, committed when the latency counter expires.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mult_div_unit_if.slave md
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo, pend_hi, pend_lo;
    logic          pend_we;
    logic [31:0]   rs, rt, a_abs, b_abs, q_mag, r_mag, sq, sr, uq, ur;
    logic [63:0]   sprod, uprod, res;
    assign rs    = md.rs_data;
    assign rt    = md.rt_data;
    assign sprod = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign uprod = {32'b0, rs} * {32'b0, rt};
    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a trap.
    assign a_abs = rs[31] ? -rs : rs;
    assign b_abs = rt[31] ? -rt : rt;
    assign q_mag = a_abs / b_abs;
    assign r_mag = a_abs % b_abs;
    assign sq    = (rs[31] ^ rt[31]) ? -q_mag : q_mag;
    assign sr    = rs[31] ? -r_mag : r_mag;
    assign uq    = rs / rt;
    assign ur    = rs % rt;
    assign res   = md.MDop == MD_MULT  ? sprod :
                   md.MDop == MD_MULTU ? uprod :
                   md.MDop == MD_DIV   ? {sr, sq} : {ur, uq};
    assign md.busy  = state == S_BUSY;
    assign md.start = md.MDop >= MD_MULT && md.MDop <= MD_DIVU && !md.cancel && state == S_IDLE;
    assign md.rdata = md.HILO_Rop == HILO_HI ? hi : md.HILO_Rop == HILO_LO ? lo : 32'h0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else if (state == S_IDLE) begin
            if (md.start) begin
                {pend_hi, pend_lo} <= res;
                pend_we <= !(md.MDop >= MD_DIV && rt == 32'h0);
                cnt     <= md.MDop <= MD_MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                state   <= S_BUSY;
            end else if (md.MDop == MD_MTHI && !md.cancel) begin
                hi <= rs;
            end else if (md.MDop == MD_MTLO && !md.cancel) begin
                lo <= rs;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                if (pend_we) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench; expected HI/LO pushed at issue, popped and compared after completion.
module tb_mult_div_unit;
    import md_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] hi_m = '0, lo_m = '0;
    mult_div_unit_if mdi();
    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(mdi.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cn);
        mdi.MDop = op;
        mdi.rs_data = a;
        mdi.rt_data = b;
        mdi.cancel = cn;
    endtask
    task automatic read_hilo(output logic [63:0] v);
        mdi.HILO_Rop = HILO_HI;
        #1 v[63:32] = mdi.rdata;
        mdi.HILO_Rop = HILO_LO;
        #1 v[31:0] = mdi.rdata;
        mdi.HILO_Rop = HILO_NONE;
    endtask
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] cur);
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint q, r;
        if (op == MD_MULT) return 64'(sa * sb_);
        if (op == MD_MULTU) return 64'(ua * ub);
        if (b == 0) return cur;
        q = op == MD_DIV ? sa / sb_ : ua / ub;
        r = op == MD_DIV ? sa % sb_ : ua % ub;
        return {32'(r), 32'(q)};
    endfunction
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [63:0] got, e;
        int n = 0;
        @(negedge clk);
        drive(op, a, b, 1'b0);
        #1 check("start", 64'(mdi.start), 64'd1);
        sb.push_back(model(op, a, b, {hi_m, lo_m}));
        @(posedge clk);
        #1 drive(MD_NONE, $urandom, $urandom, 1'b0);
        while (mdi.busy && n < 100) begin
            n++;
            if (n == inj) begin
                drive(MD_MTLO, 32'hAA, 32'h0, 1'b1);
                #1 check("start_while_busy", 64'(mdi.start), 64'd0);
            end else begin
                drive(MD_NONE, $urandom, $urandom, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 64'(n), op <= MD_MULTU ? 64'd5 : 64'd10);
        drive(MD_NONE, '0, '0, 1'b0);
        read_hilo(got);
        e = sb.pop_front();
        check("hilo", got, e);
        {hi_m, lo_m} = e;
    endtask
    task automatic move(input logic [2:0] op, input logic [31:0] a, input logic cn);
        logic [63:0] got;
        @(negedge clk);
        drive(op, a, '0, cn);
        #1 check("mv_start", 64'(mdi.start), 64'd0);
        @(posedge clk);
        #1 check("mv_busy", 64'(mdi.busy), 64'd0);
        drive(MD_NONE, '0, '0, 1'b0);
        if (!cn && op == MD_MTHI) hi_m = a;
        if (!cn && op == MD_MTLO) lo_m = a;
        read_hilo(got);
        check("mv_hilo", got, {hi_m, lo_m});
    endtask
    initial begin
        logic [63:0] got;
        drive(MD_NONE, '0, '0, 1'b0);
        mdi.HILO_Rop = HILO_NONE;
        #12;
        check("rst_busy", 64'(mdi.busy), 64'd0);
        read_hilo(got);
        check("rst_hilo", got, 64'd0);
        @(negedge clk) reset = 1'b0;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 0);
        check("mult_neg", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFEB);
        mdi.HILO_Rop = 2'b11;
        #1 check("rop_none", 64'(mdi.rdata), 64'd0);
        mdi.HILO_Rop = HILO_NONE;
        run_op(MD_DIVU, 32'd100, 32'd7, 0);
        check("divu", {hi_m, lo_m}, {32'd2, 32'd14});
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        move(MD_MTHI, 32'h1234, 1'b0);
        move(MD_MTLO, 32'h5678, 1'b0);
        run_op(MD_DIV, 32'd5, 32'd0, 0);
        check("div0", {hi_m, lo_m}, {32'h1234, 32'h5678});
        move(MD_MULT, 32'd9, 1'b1);
        move(MD_MTLO, 32'hAA, 1'b1);
        run_op(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 3);
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom_range(1, 4)), $urandom, i == 5 ? 32'd0 : $urandom, 0);
        move(MD_MTHI, 32'h77, 1'b0);
        @(negedge clk);
        drive(MD_DIV, 32'd50, 32'd3, 1'b0);
        @(posedge clk);
        #1 drive(MD_NONE, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1 check("arst_busy", 64'(mdi.busy), 64'd0);
        read_hilo(got);
        check("arst_hilo", got, 64'd0);
        @(negedge clk) reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("post_rst_busy", 64'(mdi.busy), 64'd0);
        read_hilo(got);
        check("post_rst_hilo", got, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
